// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word/address widths, fetch state encoding and the halt opcode.
package cpu_pkg;

  localparam int unsigned WordW = 8;
  localparam int unsigned AddrW = 8;

  typedef logic [WordW-1:0] word_t;
  typedef logic [AddrW-1:0] addr_t;

  typedef enum logic [0:0] {
    StFetch,
    StHalted
  } fetch_state_e;

  localparam word_t HaltOpcode = 8'h00;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: program-memory port, IR handshake to decode and redirect from execute.
interface fetch_unit_if;
  import cpu_pkg::*;

  addr_t linenumber;
  word_t instr_in;
  word_t ir_out;
  addr_t ir_pc;
  logic  ir_valid;
  logic  ir_ready;
  logic  redirect_valid;
  addr_t redirect_target;
  logic  halted;
  logic  fetch_err;

  modport master (
    output linenumber, ir_out, ir_pc, ir_valid, halted, fetch_err,
    input  instr_in, ir_ready, redirect_valid, redirect_target
  );

  modport slave (
    input  linenumber, ir_out, ir_pc, ir_valid, halted, fetch_err,
    output instr_in, ir_ready, redirect_valid, redirect_target
  );

endinterface

// File: rtl/fetch_pc.sv
// Program counter register: load takes priority over increment.
module fetch_pc
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  addr_t load_val,
  input  logic  inc,
  output addr_t pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + addr_t'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: streams program memory into a one-deep IR towards decode, honouring
// stalls, HALT words, end of program memory and redirects from execute.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned PROG_DEPTH  = 65,
  parameter word_t       HALT_OPCODE = HaltOpcode
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  localparam addr_t LastLine = addr_t'(PROG_DEPTH - 1);

  fetch_state_e state_q;
  addr_t        pc;
  word_t        ir_out_q;
  addr_t        ir_pc_q;
  logic         ir_valid_q;
  logic         fetch_err_q;

  logic target_ok;
  logic can_load;
  logic is_halt;
  logic pc_load;
  logic pc_inc;

  // Redirects outrank everything, so a load only happens in a redirect-free cycle.
  always_comb begin
    target_ok = 32'(bus.redirect_target) < PROG_DEPTH;
    can_load  = (state_q == StFetch) && (!ir_valid_q || bus.ir_ready) && !bus.redirect_valid;
    is_halt   = bus.instr_in == HALT_OPCODE;
    pc_load   = bus.redirect_valid && target_ok;
    pc_inc    = can_load && !is_halt && (pc != LastLine);
  end

  fetch_pc u_fetch_pc (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .load_val (bus.redirect_target),
    .inc      (pc_inc),
    .pc       (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StFetch;
      ir_out_q    <= '0;
      ir_pc_q     <= '0;
      ir_valid_q  <= 1'b0;
      fetch_err_q <= 1'b0;
    end else if (bus.redirect_valid) begin
      ir_valid_q <= 1'b0;
      if (target_ok) begin
        state_q <= StFetch;
      end else begin
        state_q     <= StHalted;
        fetch_err_q <= 1'b1;
      end
    end else if (can_load) begin
      if (is_halt) begin
        ir_valid_q <= 1'b0;
        state_q    <= StHalted;
      end else begin
        ir_out_q   <= bus.instr_in;
        ir_pc_q    <= pc;
        ir_valid_q <= 1'b1;
        // Last line is still issued, but fetch never wraps back to 0.
        if (pc == LastLine) begin
          state_q <= StHalted;
        end
      end
    end else if (ir_valid_q && bus.ir_ready) begin
      ir_valid_q <= 1'b0;
    end
  end

  assign bus.linenumber = pc;
  assign bus.ir_out     = ir_out_q;
  assign bus.ir_pc      = ir_pc_q;
  assign bus.ir_valid   = ir_valid_q;
  assign bus.halted     = (state_q == StHalted);
  assign bus.fetch_err  = fetch_err_q;

endmodule
